// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: load-use stalls, branch/JAL
// flushes, memory freeze and EX operand forwarding selects.
module riscv_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic             i_src1_reg_en,
  input  logic             i_src2_reg_en,
  input  logic [4:0]       i_src1_reg_addr,
  input  logic [4:0]       i_src2_reg_addr,
  input  logic [4:0]       i_dst_reg_addr,
  input  logic             i_alures2reg,
  input  logic             i_memory2reg,
  input  logic             i_jal,
  input  logic             i_branch_taken,
  input  logic             i_mem_ready,
  output logic             o_pc_hold,
  output logic             o_if_flush,
  output logic             o_ex_bubble,
  output logic             o_pipe_freeze,
  output logic [1:0]       o_fwd1_sel,
  output logic [1:0]       o_fwd2_sel,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  // Per-stage tracking; source fields are only consulted while in EX.
  logic [2:0] valid_q, valid_d;
  logic [2:0] wr_q, wr_d;
  logic [1:0] load_q, load_d;
  logic [4:0] rd_q [3];
  logic [4:0] rd_d [3];
  logic       ex_s1_en_q, ex_s1_en_d;
  logic       ex_s2_en_q, ex_s2_en_d;
  logic [4:0] ex_s1_q, ex_s1_d;
  logic [4:0] ex_s2_q, ex_s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic id_wr;
  logic lu;
  logic freeze;
  logic load_ex;

  assign id_wr  = (i_alures2reg | i_memory2reg) & (i_dst_reg_addr != 5'd0);
  assign freeze = !i_mem_ready;

  assign lu = i_id_valid & valid_q[EX] & load_q[EX] & wr_q[EX] &
              ((i_src1_reg_en & (i_src1_reg_addr == rd_q[EX])) |
               (i_src2_reg_en & (i_src2_reg_addr == rd_q[EX])));

  always_comb begin
    o_pc_hold   = 1'b0;
    o_if_flush  = 1'b0;
    o_ex_bubble = 1'b0;
    if (freeze) begin
      o_pc_hold = 1'b1;
    end else if (i_branch_taken) begin
      o_if_flush  = 1'b1;
      o_ex_bubble = 1'b1;
    end else if (lu) begin
      o_pc_hold   = 1'b1;
      o_ex_bubble = 1'b1;
    end else if (i_id_valid & i_jal) begin
      o_if_flush = 1'b1;
    end
  end

  assign o_pipe_freeze = freeze;
  assign load_ex       = i_id_valid & !o_ex_bubble;

  // EX stage next state: ID fields, or an all-zero bubble entry.
  always_comb begin
    valid_d[EX] = valid_q[EX];
    wr_d[EX]    = wr_q[EX];
    load_d[EX]  = load_q[EX];
    rd_d[EX]    = rd_q[EX];
    ex_s1_en_d  = ex_s1_en_q;
    ex_s2_en_d  = ex_s2_en_q;
    ex_s1_d     = ex_s1_q;
    ex_s2_d     = ex_s2_q;
    if (!freeze) begin
      valid_d[EX] = load_ex;
      wr_d[EX]    = load_ex & id_wr;
      load_d[EX]  = load_ex & i_memory2reg;
      rd_d[EX]    = load_ex ? i_dst_reg_addr : 5'd0;
      ex_s1_en_d  = load_ex & i_src1_reg_en;
      ex_s2_en_d  = load_ex & i_src2_reg_en;
      ex_s1_d     = load_ex ? i_src1_reg_addr : 5'd0;
      ex_s2_d     = load_ex ? i_src2_reg_addr : 5'd0;
    end
  end

  generate
    for (genvar gi = MEM; gi <= WB; gi++) begin : g_shift
      always_comb begin
        valid_d[gi] = freeze ? valid_q[gi] : valid_q[gi-1];
        wr_d[gi]    = freeze ? wr_q[gi]    : wr_q[gi-1];
        rd_d[gi]    = freeze ? rd_q[gi]    : rd_q[gi-1];
      end
    end
  endgenerate

  assign load_d[MEM] = freeze ? load_q[MEM] : load_q[EX];

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze && o_ex_bubble && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= '0;
      wr_q       <= '0;
      load_q     <= '0;
      ex_s1_en_q <= 1'b0;
      ex_s2_en_q <= 1'b0;
      ex_s1_q    <= 5'd0;
      ex_s2_q    <= 5'd0;
      cnt_q      <= '0;
      for (int i = 0; i < 3; i++) rd_q[i] <= 5'd0;
    end else begin
      valid_q    <= valid_d;
      wr_q       <= wr_d;
      load_q     <= load_d;
      ex_s1_en_q <= ex_s1_en_d;
      ex_s2_en_q <= ex_s2_en_d;
      ex_s1_q    <= ex_s1_d;
      ex_s2_q    <= ex_s2_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < 3; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign o_bubble_cnt = cnt_q;

  // Loads in MEM have no data yet, so they can only be forwarded from WB.
  logic       src_en  [2];
  logic [4:0] src_adr [2];
  logic [1:0] fwd_sel [2];

  assign src_en[0]  = ex_s1_en_q;
  assign src_en[1]  = ex_s2_en_q;
  assign src_adr[0] = ex_s1_q;
  assign src_adr[1] = ex_s2_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (valid_q[EX] && src_en[gi]) begin
          if (valid_q[MEM] && wr_q[MEM] && !load_q[MEM] && (rd_q[MEM] == src_adr[gi]))
            fwd_sel[gi] = 2'b01;
          else if (valid_q[WB] && wr_q[WB] && (rd_q[WB] == src_adr[gi]))
            fwd_sel[gi] = 2'b10;
        end
      end
    end
  endgenerate

  assign o_fwd1_sel = fwd_sel[0];
  assign o_fwd2_sel = fwd_sel[1];

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It takes the instruction decoder's per-instruction fields in ID and tracks the destination of every instruction in flight in EX, MEM and WB. From that state it generates:
- stall and flush controls for the IF/ID/EX pipeline registers;
- operand-forwarding selects for the instruction currently in EX.

## Interface

Parameters
- `CNT_W`, default 32: width of the bubble/stall statistics counter.

Ports
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_id_valid`  in  1  ID holds a real instruction (0 = bubble).
- `i_src1_reg_en`, `i_src2_reg_en`  in  1 each  source operand read enables from the decoder.
- `i_src1_reg_addr`, `i_src2_reg_addr`  in  5 each  source register indices.
- `i_dst_reg_addr`  in  5  destination register index.
- `i_alures2reg`  in  1  ALU result is written back.
- `i_memory2reg`  in  1  load; memory data is written back.
- `i_jal`  in  1  JAL in ID; target is resolved in ID.
- `i_branch_taken`  in  1  EX resolved a taken branch or JALR this cycle.
- `i_mem_ready`  in  1  data memory can complete; 0 freezes the whole pipeline.
- `o_pc_hold`  out  1  hold the PC and the IF/ID register.
- `o_if_flush`  out  1  replace the IF/ID contents with a bubble.
- `o_ex_bubble`  out  1  load a bubble into ID/EX instead of the ID instruction.
- `o_pipe_freeze`  out  1  hold every pipeline register (memory stall).
- `o_fwd1_sel`, `o_fwd2_sel`  out  2 each  operand source for EX: 00 = regfile, 01 = MEM-stage ALU result, 10 = WB-stage write data.
- `o_bubble_cnt`  out  `CNT_W`  saturating count of cycles in which `o_ex_bubble` = 1.

## Operation

- **Tracking entries.** One entry per stage: EX, MEM, WB.
  - Fields: `valid`, `wr`, `load`, `rd`, `s1_en`, `s2_en`, `s1`, `s2`.
  - `wr` = `alures2reg` | `memory2reg`, and is forced to 0 when `rd` = 0.
- **Advance.** Applies when `o_pipe_freeze` = 0. WB ← MEM, MEM ← EX, EX ← ID fields.
  - EX loads an invalid entry when `o_ex_bubble` = 1 or `i_id_valid` = 0.
- **Freeze.** `o_pipe_freeze` = !`i_mem_ready`. While frozen:
  - no entry changes and the counter does not change;
  - `o_pc_hold` = 1; `o_if_flush` = 0; `o_ex_bubble` = 0.
- **Load-use hazard.** `lu` = `i_id_valid` & EX.valid & EX.load & EX.wr & ((`i_src1_reg_en` & `i_src1_reg_addr` == EX.rd) | (`i_src2_reg_en` & `i_src2_reg_addr` == EX.rd)).
  - When `lu` = 1: `o_pc_hold` = 1 and `o_ex_bubble` = 1. Exactly one bubble is inserted per load-use pair.
- **Taken branch.** Takes priority over `lu`. When `i_branch_taken` = 1:
  - `o_if_flush` = 1, `o_ex_bubble` = 1, `o_pc_hold` = 0;
  - any `i_jal` in ID is ignored.
- **JAL.** When `i_id_valid` & `i_jal` & !`lu` & !`i_branch_taken`: `o_if_flush` = 1, one-cycle penalty.
  - JAL itself proceeds to EX; it writes rd via `alures2reg`.
- **Forwarding.** Evaluated for EX.s1 and EX.s2 independently; a source with its enable at 0 gets sel 00.
  - MEM match: MEM.valid & MEM.wr & !MEM.load & MEM.rd == src → sel 01. Takes priority over WB.
  - Otherwise WB match: WB.valid & WB.wr & WB.rd == src → sel 10.
  - Otherwise sel 00. Register x0 never matches because `wr` is 0 when `rd` = 0.
- **Counter.** `o_bubble_cnt` increments on each unfrozen cycle in which `o_ex_bubble` = 1, and holds at all-ones (saturates).
- **Reset values.** All entries invalid; `o_bubble_cnt` = 0. This yields `o_pc_hold` = 0, `o_if_flush` = 0, `o_ex_bubble` = 0, sel = 00. `o_pipe_freeze` follows `i_mem_ready`.

## Timing

- Stall, flush and bubble outputs are combinational from the current ID inputs and the registered EX entry. They are valid in the same cycle and are consumed at the next edge.
- Forward selects are combinational from registered entries only; they have no input-to-output path.
- Load-use penalty: exactly 1 cycle. The consumer enters EX one cycle later, with the load in WB, so sel = 10.
- Penalties: JAL = 1 cycle; taken branch = 2 cycles (IF and ID squashed).
- `i_rst` asserted mid-stall or mid-freeze: all entries are cleared at that edge, regardless of `i_mem_ready`.
- Freeze during a pending load-use: no bubble is counted until unfrozen; `lu` is re-evaluated each cycle.

## Test plan

- **ALU chain.** `add x5` → `add x6,x5,x5` back-to-back → second in EX has `o_fwd1_sel` = `o_fwd2_sel` = 01, no stall. With one independent instruction between them → sel 10.
- **Load-use.** `lw x7` then `add x8,x7,x1` → exactly one cycle of `o_pc_hold` = 1 and `o_ex_bubble` = 1. `add` then enters EX with `o_fwd1_sel` = 10. `o_bubble_cnt` = 1.
- **x0 destination.** `addi x0` then `add x1,x0,x0` → sel 00, no stall. `lw x0` then use of x0 → no stall.
- **Branch vs load-use.** `i_branch_taken` = 1 in the same cycle as a load-use condition → `o_if_flush` = 1, `o_ex_bubble` = 1, `o_pc_hold` = 0. JAL in ID that cycle is ignored.
- **Memory freeze.** `i_mem_ready` = 0 for 3 cycles during a load-use stall → entries and counter are unchanged. After release: a single bubble, and the count increases by exactly 1.
- **Reset.** `i_rst` during a freeze with valid entries → next cycle all outputs are at reset values; `o_bubble_cnt` = 0.
